// File: rtl/palette_pkg.sv
// Shared types and default sizes for the sprite palette block.
// Holds the colour struct, fade FSM states and a width helper.
package palette_pkg;

    localparam int DEF_IDX_W     = 4;
    localparam int DEF_CH_W      = 4;
    localparam int DEF_LVL_W     = 4;
    localparam int DEF_NUM_BANKS = 4;

    typedef struct packed {
        logic [DEF_CH_W-1:0] r;
        logic [DEF_CH_W-1:0] g;
        logic [DEF_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        FADE_IDLE,
        FADE_RUN
    } fade_state_t;

    // clog2 that never returns 0, so a one-entry range still gets a bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Global fade engine: step divider, brightness level and fade FSM.
// Ports: Clk, Reset, fade_start/fade_dir in; fade_busy, level out.
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int LVL_W    = DEF_LVL_W,
    parameter int FADE_DIV = 262144
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             fade_start,
    input  logic             fade_dir,
    output logic             fade_busy,
    output logic [LVL_W-1:0] level
);

    localparam int DIV_W = min1_clog2(FADE_DIV);
    localparam logic [LVL_W-1:0] LVL_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    fade_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] start_tgt;
    logic [LVL_W-1:0] run_tgt;
    logic [LVL_W-1:0] step;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FADE_IDLE;
            div_q   <= '0;
            dir_q   <= 1'b0;
            level_q <= LVL_MAX;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        start_tgt = fade_dir ? LVL_MAX : '0;
        run_tgt   = dir_q ? LVL_MAX : '0;
        step      = dir_q ? level_q + LVL_W'(1)
                          : level_q - LVL_W'(1);
        state_d   = state_q;
        div_d     = div_q;
        dir_d     = dir_q;
        level_d   = level_q;
        unique case (state_q)
            FADE_IDLE: begin
                if (fade_start && level_q != start_tgt) begin
                    state_d = FADE_RUN;
                    div_d   = '0;
                    dir_d   = fade_dir;
                end
            end
            FADE_RUN: begin
                if (fade_start) begin
                    // Restart from the current level; no jump.
                    div_d = '0;
                    dir_d = fade_dir;
                    if (level_q == start_tgt) begin
                        state_d = FADE_IDLE;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    level_d = step;
                    if (step == run_tgt) begin
                        state_d = FADE_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = FADE_IDLE;
        endcase
    end

    always_comb begin
        fade_busy = (state_q == FADE_RUN);
        level     = level_q;
    end

endmodule

// File: rtl/palette_bank_lut.sv
// Multi-bank writable palette with transparency and global fade.
// Ports: pix_* lookup in, wr_* write in, fade_* control, RGB out.
module palette_bank_lut
    import palette_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int CH_W       = DEF_CH_W,
    parameter int LVL_W      = DEF_LVL_W,
    parameter int TRANSP_IDX = 0,
    parameter int FADE_DIV   = 262144,
    localparam int BANK_W    = min1_clog2(NUM_BANKS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_valid,
    input  logic [BANK_W-1:0] pix_bank,
    input  logic [IDX_W-1:0]  pix_index,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              fade_start,
    input  logic              fade_dir,
    output logic              fade_busy,
    output logic [LVL_W-1:0]  level,
    output logic              out_valid,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              transparent
);

    localparam int ENTRIES    = 2 ** IDX_W;
    localparam int BANK_SLOTS = 2 ** BANK_W;
    localparam int RGB_W      = 3 * CH_W;
    localparam int PROD_W     = CH_W + LVL_W + 1;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pix_rgb_t;

    function automatic logic [CH_W-1:0] scale(
        input logic [CH_W-1:0]  c,
        input logic [LVL_W-1:0] l
    );
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * (PROD_W'(l) + PROD_W'(1));
        return CH_W'(p >> LVL_W);
    endfunction

    logic [RGB_W-1:0] bank_rd [BANK_SLOTS];

    // Bank slots past NUM_BANKS have no storage and read as black,
    // which also makes writes to them vanish.
    for (genvar b = 0; b < BANK_SLOTS; b++) begin : g_bank
        if (b < NUM_BANKS) begin : g_real
            logic [RGB_W-1:0] ent_q [ENTRIES];
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    for (int i = 0; i < ENTRIES; i++) begin
                        ent_q[i] <= '0;
                    end
                end else if (wr_en && wr_bank == BANK_W'(b)) begin
                    ent_q[wr_index] <= wr_rgb;
                end
            end
            assign bank_rd[b] = ent_q[pix_index];
        end else begin : g_none
            assign bank_rd[b] = '0;
        end
    end

    logic [LVL_W-1:0] lvl;

    palette_fade_ctrl #(
        .LVL_W    (LVL_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade (
        .Clk        (Clk),
        .Reset      (Reset),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .fade_busy  (fade_busy),
        .level      (lvl)
    );

    assign level = lvl;

    pix_rgb_t s1_rgb_q, s1_rgb_d;
    logic     s1_valid_q;
    logic     s1_transp_q;
    pix_rgb_t s2_rgb_q, s2_rgb_d;
    logic     s2_valid_q;
    logic     s2_transp_q;

    always_comb begin
        s1_rgb_d   = pix_rgb_t'(bank_rd[pix_bank]);
        s2_rgb_d.r = scale(s1_rgb_q.r, lvl);
        s2_rgb_d.g = scale(s1_rgb_q.g, lvl);
        s2_rgb_d.b = scale(s1_rgb_q.b, lvl);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_rgb_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_transp_q <= 1'b0;
            s2_rgb_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_transp_q <= 1'b0;
        end else begin
            s1_rgb_q    <= s1_rgb_d;
            s1_valid_q  <= pix_valid;
            s1_transp_q <= (pix_index == IDX_W'(TRANSP_IDX));
            s2_rgb_q    <= s2_rgb_d;
            s2_valid_q  <= s1_valid_q;
            s2_transp_q <= s1_transp_q;
        end
    end

    assign out_valid   = s2_valid_q;
    assign red         = s2_rgb_q.r;
    assign green       = s2_rgb_q.g;
    assign blue        = s2_rgb_q.b;
    assign transparent = s2_transp_q;

endmodule

// File: tb/tb_palette_bank_lut.sv
// Scoreboard bench for palette_bank_lut with directed vectors.
// Stimulus pushes expected lookups; a negedge monitor pops them.
module tb_palette_bank_lut;
    import palette_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        pix_valid;
    logic [1:0]  pix_bank;
    logic [3:0]  pix_index;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        fade_start;
    logic        fade_dir;
    logic        fade_busy;
    logic [3:0]  level;
    logic        out_valid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;

    typedef struct packed {
        rgb_t c;
        logic t;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    palette_bank_lut #(
        .IDX_W      (4),
        .NUM_BANKS  (4),
        .CH_W       (4),
        .LVL_W      (4),
        .TRANSP_IDX (0),
        .FADE_DIV   (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_valid   (pix_valid),
        .pix_bank    (pix_bank),
        .pix_index   (pix_index),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .fade_start  (fade_start),
        .fade_dir    (fade_dir),
        .fade_busy   (fade_busy),
        .level       (level),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [11:0] c, input logic t);
        exp_t e;
        e.c = c;
        e.t = t;
        sbq.push_back(e);
    endtask

    task automatic lookup(input logic [1:0] b, input logic [3:0] i,
                          input logic [11:0] c, input logic t);
        pix_valid = 1'b1;
        pix_bank  = b;
        pix_index = i;
        push(c, t);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic write(input logic [1:0] b, input logic [3:0] i,
                         input logic [11:0] c);
        wr_en    = 1'b1;
        wr_bank  = b;
        wr_index = i;
        wr_rgb   = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse(input logic dir);
        fade_dir   = dir;
        fade_start = 1'b1;
        tick();
        fade_start = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    // Monitor: every valid output must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got rgb %h want none",
                             {red, green, blue});
                end else begin
                    e = sbq.pop_front();
                    chk("lookup_rgb", int'({red, green, blue}),
                        int'(e.c));
                    chk("lookup_transp", int'(transparent), int'(e.t));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        int prev;
        Reset      = 1'b1;
        pix_valid  = 1'b0;
        pix_bank   = '0;
        pix_index  = '0;
        wr_en      = 1'b0;
        wr_bank    = '0;
        wr_index   = '0;
        wr_rgb     = '0;
        fade_start = 1'b0;
        fade_dir   = 1'b0;
        repeat (2) tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_transp", int'(transparent), 0);
        chk("rst_busy", int'(fade_busy), 0);
        chk("rst_level", int'(level), 15);
        Reset = 1'b0;
        tick();

        lookup(2'd0, 4'd5, 12'h000, 1'b0);
        lookup(2'd0, 4'd0, 12'h000, 1'b1);
        drain();

        write(2'd2, 4'd3, 12'hF81);
        lookup(2'd2, 4'd3, 12'hF81, 1'b0);
        lookup(2'd1, 4'd3, 12'h000, 1'b0);
        drain();

        wr_en     = 1'b1;
        wr_bank   = 2'd1;
        wr_index  = 4'd7;
        wr_rgb    = 12'hABC;
        pix_valid = 1'b1;
        pix_bank  = 2'd1;
        pix_index = 4'd7;
        push(12'h000, 1'b0);
        tick();
        wr_en = 1'b0;
        lookup(2'd1, 4'd7, 12'hABC, 1'b0);
        drain();

        write(2'd0, 4'd1, 12'hFFF);
        pulse(1'b0);
        c0 = cyc;
        chk("fade_busy_on", int'(fade_busy), 1);
        n = 0;
        while (level != 4'd7 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_l7", int'(level), 7);
        lookup(2'd0, 4'd1, 12'h777, 1'b0);
        n = 0;
        while (fade_busy && n < 400) begin
            tick();
            n++;
        end
        chk("fade_out_busy", int'(fade_busy), 0);
        chk("fade_out_level", int'(level), 0);
        chk("fade_out_cycles", cyc - c0, 60);
        lookup(2'd0, 4'd1, 12'h000, 1'b0);
        drain();

        pulse(1'b1);
        prev = 0;
        n = 0;
        while (level != 4'd5 && n < 200) begin
            tick();
            n++;
            if (int'(level) != prev) begin
                chk("step_up", int'(level), prev + 1);
                prev = int'(level);
            end
        end
        chk("reach_l5", int'(level), 5);
        pulse(1'b0);
        chk("no_jump", int'(level), 5);
        chk("rev_busy", int'(fade_busy), 1);
        prev = 5;
        n = 0;
        while (fade_busy && n < 400) begin
            tick();
            n++;
            if (int'(level) != prev) begin
                chk("step_down", int'(level), prev - 1);
                prev = int'(level);
            end
        end
        chk("rev_level", int'(level), 0);
        pulse(1'b0);
        chk("at_tgt_busy", int'(fade_busy), 0);
        repeat (10) tick();
        chk("at_tgt_busy2", int'(fade_busy), 0);
        chk("at_tgt_level", int'(level), 0);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                Reset = 1'b1;
                sbq.delete();
            end
            if (i == 6) Reset = 1'b0;
            pix_valid = 1'b1;
            pix_bank  = 2'd2;
            pix_index = 4'd3;
            if (i < 3 || i >= 6) push(12'h000, 1'b0);
            tick();
        end
        pix_valid = 1'b0;
        lookup(2'd0, 4'd0, 12'h000, 1'b1);
        lookup(2'd0, 4'd1, 12'h000, 1'b0);
        drain();
        chk("post_rst_level", int'(level), 15);
        chk("post_rst_busy", int'(fade_busy), 0);
        chk("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
